// File: rtl/rx_cmd_serial.sv
// rx_cmd_serial: serial command receiver with register bank, display and error flags
module rx_cmd_serial #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 2
) (
  input  logic                     clk2,
  input  logic                     rst_n,
  input  logic                     transmission,
  output logic [DATA_W+OP_W-1:0]   ledData,
  output logic [DATA_W:0]          display,
  output logic                     cmd_valid,
  output logic                     frame_err,
  output logic                     op_err,
  output logic                     busy
);
  localparam int MAX_W = (DATA_W > OP_W) ? ((DATA_W > ADDR_W) ? DATA_W : ADDR_W)
                                         : ((OP_W > ADDR_W) ? OP_W : ADDR_W);
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [2:0] {IDLE, DATA, OP, ADDR, STOP, BRK} state_t;
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W+OP_W-1:0]   led_q, led_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W:0]          disp_q, disp_d;
  logic [DATA_W-1:0]        bank_q [DEPTH];
  logic                     cmd_valid_q, frame_err_q, op_err_q, busy_q;
  logic                     exec, ferr, op_clean, op_store, op_show, op_sshow, op_clr, op_known;
  logic [OP_W-1:0]          op_v;
  logic [DATA_W-1:0]        data_v;
  // state and bit-counter register
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state; the counter reloads with the field length minus one on each field entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = transmission ? IDLE : DATA;
        cnt_d   = CNT_W'(DATA_W - 1);
      end
      DATA: begin
        state_d = (cnt_q == '0) ? OP : DATA;
        cnt_d   = (cnt_q == '0) ? CNT_W'(OP_W - 1) : cnt_q - 1'b1;
      end
      OP: begin
        state_d = (cnt_q == '0) ? ADDR : OP;
        cnt_d   = (cnt_q == '0) ? CNT_W'(ADDR_W - 1) : cnt_q - 1'b1;
      end
      ADDR: begin
        state_d = (cnt_q == '0) ? STOP : ADDR;
        cnt_d   = cnt_q - 1'b1;
      end
      STOP:    state_d = transmission ? IDLE : BRK;
      BRK:     state_d = transmission ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  // field capture, opcode decode and next display value
  always_comb begin
    op_v     = led_q[OP_W-1:0];
    data_v   = led_q[OP_W +: DATA_W];
    exec     = (state_q == STOP) && transmission;
    ferr     = (state_q == STOP) && !transmission;
    op_clean = op_v == OP_W'(1);
    op_store = op_v == OP_W'(2);
    op_show  = op_v == OP_W'(4);
    op_sshow = op_v == OP_W'(6);
    op_clr   = op_v == OP_W'(8);
    op_known = (op_v == '0) || op_clean || op_store || op_show || op_sshow || op_clr;
    led_d    = led_q;
    addr_d   = addr_q;
    if (state_q == DATA) led_d[OP_W + int'(cnt_q)] = transmission;
    if (state_q == OP) led_d[int'(cnt_q)] = transmission;
    if (state_q == ADDR) addr_d[int'(cnt_q)] = transmission;
    disp_d = !exec               ? disp_q :
             (op_clean || op_clr) ? {1'b1, {DATA_W{1'b0}}} :
             op_show              ? {1'b0, bank_q[addr_q]} :
             op_sshow             ? {1'b0, data_v} : disp_q;
  end
  // datapath, bank writes and registered status pulses
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= '0;
      addr_q      <= '0;
      disp_q      <= {1'b1, {DATA_W{1'b0}}};
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      op_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < DEPTH; k++) bank_q[k] <= '0;
    end else begin
      led_q       <= led_d;
      addr_q      <= addr_d;
      disp_q      <= disp_d;
      cmd_valid_q <= exec;
      frame_err_q <= ferr;
      op_err_q    <= exec && !op_known;
      busy_q      <= state_d != IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        if (exec && op_clr) bank_q[k] <= '0;
        else if (exec && (op_store || op_sshow) && addr_q == ADDR_W'(k)) bank_q[k] <= data_v;
      end
    end
  end
  assign ledData   = led_q;
  assign display   = disp_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign op_err    = op_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_rx_cmd_serial.sv
// tb_rx_cmd_serial: randomized scoreboard bench for rx_cmd_serial
module tb_rx_cmd_serial;
  logic       clk2, rst_n, transmission;
  logic [7:0] ledData;
  logic [4:0] display;
  logic       cmd_valid, frame_err, op_err, busy;
  int tests = 0, fails = 0;
  typedef struct {
    bit         fe;
    bit         oe;
    logic [4:0] disp;
    logic [7:0] led;
  } exp_t;
  exp_t       q[$];
  exp_t       e;
  logic [3:0] bank_m [4];
  logic [4:0] disp_m;
  rx_cmd_serial #(.DATA_W(4), .OP_W(4), .ADDR_W(2)) dut (
    .clk2(clk2), .rst_n(rst_n), .transmission(transmission),
    .ledData(ledData), .display(display), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .op_err(op_err), .busy(busy)
  );
  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    foreach (bank_m[k]) bank_m[k] = 4'd0;
    disp_m = 5'b10000;
  endfunction
  function automatic exp_t model(input logic [3:0] d, input logic [3:0] op, input logic [1:0] a, input bit stop);
    exp_t r;
    r.fe  = !stop;
    r.oe  = 1'b0;
    r.led = {d, op};
    if (stop) begin
      case (op)
        4'd0: ;
        4'd1: disp_m = 5'b10000;
        4'd2: bank_m[a] = d;
        4'd4: disp_m = {1'b0, bank_m[a]};
        4'd6: begin bank_m[a] = d; disp_m = {1'b0, d}; end
        4'd8: begin foreach (bank_m[k]) bank_m[k] = 4'd0; disp_m = 5'b10000; end
        default: r.oe = 1'b1;
      endcase
    end
    r.disp = disp_m;
    return r;
  endfunction
  task automatic send_bit(input logic b);
    transmission = b;
    @(posedge clk2);
    #1;
  endtask
  task automatic send_frame(input logic [3:0] d, input logic [3:0] op, input logic [1:0] a, input bit stop);
    logic [11:0] fr;
    fr = {1'b0, d, op, a, stop};
    q.push_back(model(d, op, a, stop));
    for (int i = 11; i >= 0; i--) send_bit(fr[i]);
  endtask
  always @(negedge clk2) begin
    if (rst_n && (cmd_valid || frame_err || op_err)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: cmd_valid=%b frame_err=%b op_err=%b with no frame pending", cmd_valid, frame_err, op_err);
      end else begin
        e = q.pop_front();
        check("cmd_valid", cmd_valid, !e.fe);
        check("frame_err", frame_err, e.fe);
        check("op_err", op_err, e.oe);
        check("display", display, e.disp);
        check("ledData", ledData, e.led);
      end
    end
  end
  initial begin
    logic [3:0]  ops [10];
    logic [11:0] fr;
    ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd3, 4'd5, 4'd15, 4'd7};
    rst_n = 1'b0;
    transmission = 1'b1;
    model_reset();
    repeat (3) @(posedge clk2);
    #1;
    check("reset_display", display, 5'b10000);
    check("reset_led", ledData, 8'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_pulses", {cmd_valid, frame_err, op_err}, 3'b000);
    rst_n = 1'b1;
    repeat (20) send_bit(1'b1);
    check("idle_display", display, 5'b10000);
    check("idle_led", ledData, 8'd0);
    check("idle_busy", busy, 1'b0);
    send_frame(4'b1010, 4'd2, 2'd1, 1'b1);
    send_frame(4'b0000, 4'd4, 2'd1, 1'b1);
    send_frame(4'b0000, 4'd1, 2'd0, 1'b1);
    send_frame(4'b1111, 4'd6, 2'd3, 1'b1);
    send_frame(4'b0000, 4'd8, 2'd0, 1'b1);
    send_frame(4'b0000, 4'd4, 2'd3, 1'b1);
    send_frame(4'b0101, 4'd2, 2'd2, 1'b0);
    repeat (5) send_bit(1'b0);
    check("break_busy", busy, 1'b1);
    send_bit(1'b1);
    check("break_exit_busy", busy, 1'b0);
    send_frame(4'b0000, 4'd4, 2'd2, 1'b1);
    send_frame(4'b1100, 4'd3, 2'd1, 1'b1);
    send_frame(4'b0111, 4'd6, 2'd0, 1'b1);
    fr = {1'b0, 4'b1001, 4'd2, 2'd1, 1'b1};
    for (int i = 11; i >= 6; i--) send_bit(fr[i]);
    transmission = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_display", display, 5'b10000);
    check("midreset_led", ledData, 8'd0);
    check("midreset_busy", busy, 1'b0);
    @(posedge clk2);
    #1;
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);
    send_frame(4'b0000, 4'd4, 2'd1, 1'b1);
    send_frame(4'b0000, 4'd4, 2'd0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      bit         stop;
      op   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
      stop = $urandom_range(0, 7) != 0;
      send_frame(4'($urandom), op, 2'($urandom), stop);
      if (!stop) begin
        repeat ($urandom_range(0, 4)) send_bit(1'b0);
        send_bit(1'b1);
      end
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end
    for (int t = 0; t < 50 && q.size() != 0; t++) send_bit(1'b1);
    check("queue_drained", q.size(), 0);
    check("final_busy", busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
